demux_1x16_deser: RTL and testbench
===================================

Name: demux_1x16_deser

Overview:
- Inverse of the 16:1 select mux: steers one serial input bit per accepted beat into lane sel of a 16-bit assembly word.
- sel auto-increments 0..DATA_WIDTH-1.
- Completed words move to an output holding register and are presented with a valid/ready handshake.
- Used wherever a bit stream produced by the mux (sel sweeping 0..15, LSB first) must be rebuilt into a parallel word.

Parameters:
- DATA_WIDTH, 16, number of output lanes / bits per word.
- SEL_WIDTH, 4, lane index width; must equal clog2(DATA_WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of the partial word and lane counter; the holding register is unaffected.
- d_in  input  1  serial data bit.
- in_valid  input  1  d_in is valid this cycle.
- in_ready  output  1  block accepts d_in this cycle.
- out_data  output  DATA_WIDTH  assembled word; bit k is the k-th accepted bit of the word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes out_data this cycle.
- sel  output  SEL_WIDTH  lane the next accepted bit will be written to.

Behaviour:
- Reset (async, rst=1): sel=0, assembly register=0, out_data=0, out_valid=0, in_ready=1. All outputs are registered except in_ready.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - assembly[sel] <= d_in; other lanes hold.
  - sel <= sel+1, wrapping from DATA_WIDTH-1 to 0.
- Word complete: an accept with sel==DATA_WIDTH-1.
  - If the holding register is free or being drained this cycle (out_valid==0, or out_ready==1): out_data <= assembled word including this bit, and out_valid <= 1 on the next cycle. Latency from the last bit accepted to out_valid=1 is 1 cycle.
  - Assembly register clears to 0 and sel returns to 0.
- Output drain: out_valid && out_ready with no new word completing sets out_valid <= 0. out_data holds its last value; it is not cleared.
- Simultaneous drain and completion: out_valid stays 1, out_data takes the new word, and there is no bubble. Sustained throughput is 1 bit/cycle.
- in_ready = !(sel==DATA_WIDTH-1 && out_valid && !out_ready).
  - Combinational, derived only from registered state and out_ready.
  - The final bit of a word is refused while the holding register is full and not draining.
  - Bits 0..DATA_WIDTH-2 are always accepted (double buffering).
- Control states (derived from sel and out_valid):
  - EMPTY: sel=0, out_valid=0.
  - COLLECT: collecting with no pending output.
  - COLLECT_FULL: collecting while out_valid=1.
  - STALL: sel=DATA_WIDTH-1, out_valid=1, out_ready=0.
  - Each transition follows from the rules above. STALL is exited only by out_ready=1.
- flush:
  - sel <= 0 and assembly <= 0. Any bit presented in the same cycle is dropped.
  - in_ready still reports as computed.
  - out_valid and out_data are unaffected.
  - flush has priority over accept.
- Gaps: in_valid=0 cycles hold all state. Partial words persist indefinitely.
- Reset mid-word or mid-stall: immediate return to reset values. The partial word and any undelivered output are lost.
- sel out-of-range values are unreachable. With DATA_WIDTH < 2**SEL_WIDTH, the wrap occurs at DATA_WIDTH-1, not at counter overflow.
- No X propagation: d_in=X while in_valid=0 must not alter state.

Test Plan:
- Reset then stream 16'hB0F3 LSB first (1,1,0,0,1,1,1,1,0,0,0,0,1,1,0,1), one bit per cycle, out_ready=1 -> one cycle after the 16th bit: out_valid=1, out_data=16'hB0F3, sel=0. out_valid drops the next cycle.
- Back-to-back words 16'hB0F3 then 16'h5A5A, continuous in_valid, out_ready=1 -> in_ready stays 1 for all 32 cycles. out_data=16'hB0F3 then 16'h5A5A on consecutive word boundaries, with no bubble.
- Hold out_ready=0 and send 16'hB0F3 then 16'hFFFF -> after 31 bits, sel=15 and in_ready=0 (STALL) while out_data stays 16'hB0F3. Pulse out_ready=1 -> 16th bit accepted, and next cycle out_data=16'hFFFF with out_valid=1.
- Send 7 bits (all 1), assert flush for one cycle with in_valid=1, then send 16'h0001 -> sel=0 after flush, the flushed bit is dropped, and out_data=16'h0001, not contaminated.
- Assert rst asynchronously (mid-cycle) after 9 bits while out_valid=1 -> out_valid, out_data, and sel are 0 immediately, before the next clock edge, and in_ready=1.
- Insert random in_valid=0 gaps while streaming 16'h8001 -> out_data=16'h8001. State is frozen during gaps, including when d_in=X with in_valid=0.

Source files
------------

// File: rtl/demux_1x16_deser.sv
// Serial-to-parallel deserializer: steers one bit per accepted beat into lane sel,
// hands completed words to a double-buffered holding register with valid/ready output.
module demux_1x16_deser #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  d_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_WIDTH-1:0]  sel
);

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    EMPTY,
    COLLECT,
    COLLECT_FULL,
    STALL
  } ctrl_state_e;

  ctrl_state_e             ctrl_state;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   word_full;
  logic                    last_lane;
  logic                    accept;
  logic                    drain;

  // Control state is a pure decode of sel/out_valid; STALL also depends on out_ready.
  always_comb begin
    last_lane  = (sel_q == LAST_SEL);
    ctrl_state = COLLECT;
    if (out_valid_q) begin
      ctrl_state = (last_lane && !out_ready) ? STALL : COLLECT_FULL;
    end else if (sel_q == '0) begin
      ctrl_state = EMPTY;
    end
    in_ready = (ctrl_state != STALL);
  end

  always_comb begin
    accept      = in_valid && in_ready && !flush;
    drain       = out_valid_q && out_ready;
    sel_d       = sel_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    word_full   = asm_q;
    word_full[sel_q] = d_in;

    if (flush) begin
      sel_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (last_lane) begin
        sel_d = '0;
        asm_d = '0;
      end else begin
        sel_d = sel_q + SEL_WIDTH'(1);
        asm_d = word_full;
      end
    end

    // in_ready guarantees the holding register is free or draining when a word completes.
    if (accept && last_lane) begin
      out_data_d  = word_full;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Scoreboard bench for demux_1x16_deser: a bit-queue reference model predicts words
// and handshake outputs; a monitor pops expected words on each output transfer.
module tb_demux_1x16_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        d_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  sel;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned retries = 0;

  logic [15:0] exp_q[$];
  bit          cur[$];
  bit          hold_full = 1'b0;

  demux_1x16_deser #(.DATA_WIDTH(16), .SEL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current word is a queue of accepted bits; a word completes at 16 bits.
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      exp_q.delete();
      hold_full = 1'b0;
    end else begin
      bit exp_rdy;
      bit completed;
      logic [15:0] w;
      exp_rdy   = !(cur.size() == 15 && hold_full && !out_ready);
      completed = 1'b0;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("sel", {28'd0, sel}, cur.size());
      check("out_valid", {31'd0, out_valid}, {31'd0, hold_full});
      if (flush) begin
        cur.delete();
      end else if (in_valid && exp_rdy) begin
        cur.push_back(d_in);
        if (cur.size() == 16) begin
          w = '0;
          for (int i = 0; i < 16; i++) if (cur[i]) w = w + (16'd1 << i);
          exp_q.push_back(w);
          cur.delete();
          completed = 1'b1;
        end
      end
      if (completed) hold_full = 1'b1;
      else if (hold_full && out_ready) hold_full = 1'b0;
    end
  end

  // Monitor: every output transfer must match the oldest predicted word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e});
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic f, input logic r);
    in_valid = v; d_in = d; flush = f; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic r);
    bit ok;
    int unsigned tries;
    tries = 0;
    ok = 1'b0;
    while (!ok) begin
      in_valid = 1'b1; d_in = b; flush = 1'b0; out_ready = r;
      #1;
      ok = in_ready;
      if (!ok) retries++;
      @(posedge clk);
      #1;
      tries++;
      if (!ok && tries > 64) begin
        check("send_bit_timeout", 32'd0, 32'd1);
        ok = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic r);
    for (int i = 0; i < 16; i++) send_bit(w[i], r);
  endtask

  initial begin
    logic [15:0] wv;
    logic [15:0] rw;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single word, latency one cycle after last bit
    send_word(16'hB0F3, 1'b1);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data", {16'd0, out_data}, 32'h0000_B0F3);
    check("t1_sel", {28'd0, sel}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back words without a bubble
    retries = 0;
    send_word(16'hB0F3, 1'b1);
    check("t2_first", {16'd0, out_data}, 32'h0000_B0F3);
    send_word(16'h5A5A, 1'b1);
    check("t2_second", {16'd0, out_data}, 32'h0000_5A5A);
    check("t2_no_stall", retries, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Stall on the last bit while the holding register is full
    send_word(16'hB0F3, 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
    check("t3_sel", {28'd0, sel}, 32'd15);
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_hold_sel", {28'd0, sel}, 32'd15);
    check("t3_hold_data", {16'd0, out_data}, 32'h0000_B0F3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t3_new_data", {16'd0, out_data}, 32'h0000_FFFF);
    check("t3_new_valid", {31'd0, out_valid}, 32'd1);
    check("t3_sel_wrap", {28'd0, sel}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush drops partial word and the bit presented with it
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("t4_sel", {28'd0, sel}, 32'd0);
    send_word(16'h0001, 1'b1);
    check("t4_data", {16'd0, out_data}, 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-word with a pending output
    wv = 16'($urandom) | 16'h0001;
    send_word(wv, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_data", {16'd0, out_data}, 32'd0);
    check("t5_sel", {28'd0, sel}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst = 1'b0;

    // Gaps with d_in unknown while in_valid is low
    rw = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'bx, 1'b0, 1'b1);
      send_bit(rw[i], 1'b1);
    end
    check("t6_data", {16'd0, out_data}, 32'h0000_8001);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
